slice_add_seq: RTL and testbench

SLICE_ADD_SEQ -- requirements
Module: slice_add_seq

---
 rtl/slice_add_seq.sv | 98 +++++++++
 tb/tb_slice_add_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/slice_add_seq.sv
// rtl/slice_add_seq.sv - multi-cycle W-bit adder reusing one N-bit slice stage, LSB slice first
// Optional feature macro: SLICE_ADD_SEQ_OVF_EN adds the signed-overflow output ovf.
module slice_add_seq #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*M-1:0] a,
    input  logic [N*M-1:0] b,
    input  logic           ci,
    output logic           busy,
    output logic           done,
    output logic [N*M-1:0] sum,
    output logic           co
`ifdef SLICE_ADD_SEQ_OVF_EN
    ,
    output logic           ovf
`endif
);

    localparam int W  = N * M;
    localparam int KW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   a_r, b_r;
    logic [KW-1:0]  k;
    logic           carry;
    logic [N:0]     slice_sum;
    logic           last;
    logic           accept;

    assign last      = (k == KW'(M - 1));
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign slice_sum = {1'b0, a_r[k*N +: N]} + {1'b0, b_r[k*N +: N]} + {{N{1'b0}}, carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            k     <= '0;
            carry <= 1'b0;
            sum   <= '0;
            co    <= 1'b0;
`ifdef SLICE_ADD_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            carry <= ci;
            k     <= '0;
        end else if (state == RUN) begin
            sum[k*N +: N] <= slice_sum[N-1:0];
            carry         <= slice_sum[N];
            k             <= k + KW'(1);
            if (last) begin
                co <= slice_sum[N];
`ifdef SLICE_ADD_SEQ_OVF_EN
                // carry into the MSB is recovered from the MSB sum bit and its operand bits
                ovf <= (slice_sum[N-1] ^ a_r[W-1] ^ b_r[W-1]) ^ slice_sum[N];
`endif
            end
        end
    end

endmodule

// File: tb/tb_slice_add_seq.sv
// tb/tb_slice_add_seq.sv - scoreboard bench for slice_add_seq (N=4, M=4)
module tb_slice_add_seq;

    localparam int N = 4;
    localparam int M = 4;

    typedef struct {
        logic [15:0] s;
        logic        c;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        co;
`ifdef SLICE_ADD_SEQ_OVF_EN
    logic        ovf;
`endif

    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    slice_add_seq #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
`ifdef SLICE_ADD_SEQ_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("sum", {16'h0, sum}, {16'h0, e.s});
                chk("co", {31'h0, co}, {31'h0, e.c});
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", {31'h0, busy}, 32'h0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Launch one operation; done is due in the cycle after accept edge + M
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb2, input logic tci,
                         input logic [15:0] es, input logic ec);
        exp_t e;
        a     = ta;
        b     = tb2;
        ci    = tci;
        start = 1'b1;
        e.s   = es;
        e.c   = ec;
        e.cyc = cyc + 1 + M;
        sb.push_back(e);
        step();
        start = 1'b0;
        chk("busy_after_accept", {31'h0, busy}, 32'h1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        ci    = 1'b0;
        repeat (3) step();
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_sum", {16'h0, sum}, 32'h0);
        chk("rst_co", {31'h0, co}, 32'h0);
        rst = 1'b0;
        step();

        issue(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        wait_drain();
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        wait_drain();
        issue(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
        wait_drain();

        // start held high through RUN with new operands must be ignored
        issue(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
        a     = 16'h1234;
        b     = 16'h1234;
        start = 1'b1;
        repeat (M) step();
        start = 1'b0;
        wait_drain();
        step();
        chk("idle_hold_sum", {16'h0, sum}, 32'h0001);
        chk("idle_done", {31'h0, done}, 32'h0);

        // back-to-back: start accepted in DONE
        issue(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);
        wait_drain();

        // reset after two RUN edges aborts with no done pulse
        a     = 16'h1234;
        b     = 16'h1111;
        ci    = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_sum", {16'h0, sum}, 32'h0);
        chk("abort_co", {31'h0, co}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        repeat (6) step();

        issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
        wait_drain();
        issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        wait_drain();

`ifdef SLICE_ADD_SEQ_OVF_EN
        issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        wait_drain();
        chk("ovf_pos", {31'h0, ovf}, 32'h1);
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        wait_drain();
        chk("ovf_wrap", {31'h0, ovf}, 32'h0);
`endif

        repeat (2) step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
